// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_seq_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned MULDIV_LAT = DATA_W + 5;

    typedef logic [FUNCT_W-1:0] funct_t;

    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;
    localparam funct_t FUNCT_ADD   = 6'h20;
    localparam funct_t FUNCT_ADDU  = 6'h21;
    localparam funct_t FUNCT_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP1 = 3'd1,
        ST_PREP2 = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX1  = 3'd4,
        ST_FIX2  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Per-op attributes captured at start; neg1/neg2 are the original operand signs.
    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic neg1;
        logic neg2;
    } op_info_t;

    function automatic logic is_muldiv(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq_adder_flags.sv
// Recovers carry (ADDU) and borrow (SUBU) of the shared adder from operand/result MSBs.
module muldiv_seq_adder_flags (
    input  logic a_msb,
    input  logic b_msb,
    input  logic r_msb,
    output logic carry_c,
    output logic borrow_c
);

    always_comb begin
        carry_c  = (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
        borrow_c = (~a_msb & b_msb) | (~(a_msb ^ b_msb) & r_msb);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the EX-stage adder for WIDTH+4 cycles.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    input  logic               flush,
    output logic               stall_req,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               add_req,
    output logic [FUNCT_W-1:0] add_funct,
    output logic [WIDTH-1:0]   add_op1,
    output logic [WIDTH-1:0]   add_op2,
    input  logic [WIDTH-1:0]   add_result
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    op_info_t         op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q, b_q, acc_q, lo_q;
    logic [WIDTH-1:0] rem_sh_c;
    logic             valid_start_c, carry_c, borrow_c, accept_c;
    logic             op1_neg_c, op2_neg_c, neg_lo_c, neg_hi_c;

    assign valid_start_c = start & is_muldiv(funct);
    assign rem_sh_c      = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign accept_c      = acc_q[WIDTH-1] | ~borrow_c;
    assign op1_neg_c     = op_q.is_signed & a_q[WIDTH-1];
    assign op2_neg_c     = op_q.is_signed & b_q[WIDTH-1];
    assign neg_lo_c      = op_q.neg1 ^ op_q.neg2;
    assign neg_hi_c      = op_q.is_div ? op_q.neg1 : neg_lo_c;

    muldiv_seq_adder_flags u_flags (
        .a_msb    (add_op1[WIDTH-1]),
        .b_msb    (add_op2[WIDTH-1]),
        .r_msb    (add_result[WIDTH-1]),
        .carry_c  (carry_c),
        .borrow_c (borrow_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (valid_start_c) state_nxt = ST_PREP1;
                ST_PREP1: state_nxt = ST_PREP2;
                ST_PREP2: state_nxt = ST_ITER;
                ST_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX1;
                ST_FIX1:  state_nxt = ST_FIX2;
                ST_FIX2:  state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Adder requests: negate in PREP/FIX, add (mult) or trial-subtract (div) in ITER.
    always_comb begin
        stall_req = 1'b0;
        done      = 1'b0;
        add_req   = 1'b0;
        add_funct = FUNCT_ADDU;
        add_op1   = '0;
        add_op2   = '0;
        case (state)
            ST_IDLE: stall_req = valid_start_c;
            ST_PREP1: begin
                stall_req = 1'b1;
                add_req   = 1'b1;
                add_funct = FUNCT_SUBU;
                add_op2   = a_q;
            end
            ST_PREP2: begin
                stall_req = 1'b1;
                add_req   = 1'b1;
                add_funct = FUNCT_SUBU;
                add_op2   = b_q;
            end
            ST_ITER: begin
                stall_req = 1'b1;
                add_req   = 1'b1;
                if (op_q.is_div) begin
                    add_funct = FUNCT_SUBU;
                    add_op1   = rem_sh_c;
                    add_op2   = b_q;
                end else begin
                    add_op1   = acc_q;
                    add_op2   = lo_q[0] ? a_q : '0;
                end
            end
            ST_FIX1: begin
                stall_req = 1'b1;
                add_req   = 1'b1;
                add_funct = FUNCT_SUBU;
                add_op2   = lo_q;
            end
            ST_FIX2: begin
                stall_req = 1'b1;
                add_req   = 1'b1;
                if (op_q.is_div) begin
                    add_funct = FUNCT_SUBU;
                    add_op2   = acc_q;
                end else begin
                    // 64-bit product negation: hi = ~hi + (lo == 0)
                    add_op1   = ~acc_q;
                    add_op2   = WIDTH'(lo_q == '0);
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            cnt   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (valid_start_c) begin
                    a_q  <= operand_1;
                    b_q  <= operand_2;
                    op_q <= '{is_div:    (funct == FUNCT_DIV) || (funct == FUNCT_DIVU),
                              is_signed: (funct == FUNCT_DIV) || (funct == FUNCT_MULT),
                              neg1:      1'b0,
                              neg2:      1'b0};
                end
                ST_PREP1: begin
                    op_q.neg1 <= op1_neg_c;
                    if (op1_neg_c) a_q <= add_result;
                end
                ST_PREP2: begin
                    op_q.neg2 <= op2_neg_c;
                    if (op2_neg_c) b_q <= add_result;
                    acc_q <= '0;
                    lo_q  <= op_q.is_div ? a_q : (op2_neg_c ? add_result : b_q);
                    cnt   <= '0;
                end
                ST_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_q.is_div) begin
                        acc_q <= accept_c ? add_result : rem_sh_c;
                        lo_q  <= {lo_q[WIDTH-2:0], accept_c};
                    end else begin
                        acc_q <= {carry_c, add_result[WIDTH-1:1]};
                        lo_q  <= {add_result[0], lo_q[WIDTH-1:1]};
                    end
                end
                ST_FIX1: if (neg_lo_c) lo_q <= add_result;
                ST_FIX2: if (!flush) begin
                    hi <= neg_hi_c ? add_result : acc_q;
                    lo <= lo_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, abort/ignore sequences, random sweep.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int unsigned W   = DATA_W;
    localparam int          LAT = int'(MULDIV_LAT);

    logic               clk = 1'b0;
    logic               rst_n, start, flush;
    logic [FUNCT_W-1:0] funct;
    logic [W-1:0]       operand_1, operand_2;
    logic               stall_req, done, add_req;
    logic [W-1:0]       hi, lo;
    logic [FUNCT_W-1:0] add_funct;
    logic [W-1:0]       add_op1, add_op2, add_result;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .funct      (funct),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .flush      (flush),
        .stall_req  (stall_req),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .add_req    (add_req),
        .add_funct  (add_funct),
        .add_op1    (add_op1),
        .add_op2    (add_op2),
        .add_result (add_result)
    );

    // The shared EX-stage adder
    assign add_result = (add_funct == FUNCT_SUBU) ? add_op1 - add_op2 : add_op1 + add_op2;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition of each op.
    function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0;
        rl = '0;
        case (f)
            FUNCT_MULTU: begin
                p  = {32'h0, a} * {32'h0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            FUNCT_MULT: begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            FUNCT_DIVU: begin
                if (b == 0) begin
                    rl = '1;
                    rh = a;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: begin
                q  = sa / sb;
                r  = sa % sb;
                p  = 64'(q);
                rl = p[31:0];
                p  = 64'(r);
                rh = p[31:0];
            end
        endcase
    endfunction

    // Presents one op in the current cycle and follows it to done (lat) or to an abort.
    // abort_kind: 0 none, 1 flush, 2 reset; applied in cycle T+abort_at.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int abort_at, input int abort_kind,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int bad);
        lat = -1;
        bad = 0;
        rh  = '0;
        rl  = '0;
        start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
        #1;
        if (stall_req !== 1'b1 || add_req !== 1'b0 || done !== 1'b0) bad++;
        for (int n = 1; n <= LAT + 4; n++) begin
            @(posedge clk); #1;
            start = 1'b0; funct = FUNCT_ADDU; flush = 1'b0; rst_n = 1'b1;
            if (n == inject_at) begin
                start = 1'b1; funct = FUNCT_DIV;
                operand_1 = $urandom; operand_2 = $urandom;
            end
            if (n == abort_at && abort_kind == 1) flush = 1'b1;
            if (n == abort_at && abort_kind == 2) rst_n = 1'b0;
            #1;
            if (stall_req !== (n < LAT) || add_req !== (n < LAT)) bad++;
            if (done === 1'b1) begin
                lat = n;
                rh  = hi;
                rl  = lo;
                break;
            end
            if (n == abort_at) break;
        end
        @(posedge clk); #1;
        start = 1'b0; funct = FUNCT_ADDU; flush = 1'b0; rst_n = 1'b1;
        #1;
    endtask

    task automatic watch_no_done(input string nm);
        int pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) pulses++;
        end
        check(nm, 64'(pulses), 64'd0);
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rh, rl, eh, el, ph, pl;
    int          lat, bad;
    logic [5:0]  ops[4];

    initial begin
        vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{FUNCT_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[4] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{FUNCT_MULTU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
        vecs[6] = '{FUNCT_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{FUNCT_MULT,  32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000};
        vecs[9] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        ops = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = FUNCT_ADDU;
        operand_1 = '0; operand_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_add_req", 64'(add_req), 64'd0);
        check("reset_stall_idle", 64'(stall_req), 64'd0);
        start = 1'b1; funct = FUNCT_MULT;
        #1;
        check("reset_stall_start", 64'(stall_req), 64'd1);
        start = 1'b0; funct = FUNCT_ADDU; rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, 0, 0, rh, rl, lat, bad);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_profile", i), 64'(bad), 64'd0);
            check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
        end
        ph = vecs[9].hi;
        pl = vecs[9].lo;

        // Flush at T+10, then a new op started at T+11
        run_op(FUNCT_MULTU, 32'd3, 32'd4, 0, 10, 1, rh, rl, lat, bad);
        check("flush_no_done", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
        check("flush_profile", 64'(bad), 64'd0);
        check("flush_idle_stall", 64'(stall_req), 64'd0);
        check("flush_idle_add_req", 64'(add_req), 64'd0);
        check("flush_hi_kept", 64'(hi), 64'(ph));
        check("flush_lo_kept", 64'(lo), 64'(pl));
        run_op(FUNCT_MULTU, 32'd6, 32'd9, 0, 0, 0, rh, rl, lat, bad);
        check("after_flush_latency", 64'(lat), 64'(LAT));
        check("after_flush_lo", 64'(rl), 64'd54);
        watch_no_done("after_flush_quiet");

        // Invalid funct in IDLE, then a start injected during ITER
        start = 1'b1; funct = FUNCT_ADD; operand_1 = 32'd5; operand_2 = 32'd5;
        #1;
        check("add_funct_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("add_funct_ignored", 64'(add_req), 64'd0);
        run_op(FUNCT_MULT, 32'hFFFFFFFD, 32'd7, 10, 0, 0, rh, rl, lat, bad);
        check("inject_latency", 64'(lat), 64'(LAT));
        check("inject_profile", 64'(bad), 64'd0);
        check("inject_result", {rh, rl}, 64'hFFFFFFFF_FFFFFFEB);

        // Reset at T+20
        run_op(FUNCT_DIVU, 32'd100, 32'd7, 0, 20, 2, rh, rl, lat, bad);
        check("rst_no_done", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_add_req", 64'(add_req), 64'd0);
        watch_no_done("rst_quiet");

        // Random sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 99)) - 32'd50;
            if (f == FUNCT_DIV && b == 0) b = 32'd3;
            ref_model(f, a, b, eh, el);
            run_op(f, a, b, 0, 0, 0, rh, rl, lat, bad);
            check($sformatf("rnd%0d_f%0h_%h_%h_latency", i, f, a, b), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_f%0h_%h_%h_result", i, f, a, b), {rh, rl}, {eh, el});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
